// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and memory-wait/timeout control for a 5-stage pipe.
// Define HAZARD_PERF_CNT_EN to add the saturating stall-cycle counter output stall_cnt.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        is_branch,
   input  logic        mem_busy,
   output logic        pc_write,
   output logic        ifd_write,
   output logic        ifd_flush,
   output logic        idex_bubble,
   output logic [1:0]  state,
   output logic        timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2, ERROR = 2'd3} state_t;
   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
   state_t cur, nxt;
   logic [1:0] fcnt, fcnt_nxt;
   logic [7:0] wcnt, wcnt_nxt;
   logic       terr_nxt, busy, branch, load_use;
   // Inputs are masked while in reset so the outputs decode as an idle RUN.
   assign busy     = rst_n & mem_busy;
   assign branch   = rst_n & is_branch;
   assign load_use = rst_n & ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
   assign state    = cur;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur         <= RUN;
         fcnt        <= 2'd0;
         wcnt        <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         cur         <= nxt;
         fcnt        <= fcnt_nxt;
         wcnt        <= wcnt_nxt;
         timeout_err <= terr_nxt;
      end
   end
   always_comb begin
      nxt      = cur;
      fcnt_nxt = fcnt;
      wcnt_nxt = wcnt;
      terr_nxt = timeout_err;
      case (cur)
         RUN: begin
            if (busy) begin
               nxt      = MEM_WAIT;
               wcnt_nxt = 8'd1;
            end else if (branch) begin
               fcnt_nxt = FLUSH_INIT;
               nxt      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            if (busy) begin
               nxt      = MEM_WAIT;
               wcnt_nxt = 8'd1;
            end else begin
               fcnt_nxt = fcnt - 2'd1;
               nxt      = (fcnt == 2'd1) ? RUN : FLUSH;
            end
         end
         MEM_WAIT: begin
            if (!busy) begin
               wcnt_nxt = 8'd0;
               nxt      = (fcnt != 2'd0) ? FLUSH : RUN;
            end else if (wcnt == TIMEOUT) begin
               nxt      = ERROR;
               terr_nxt = 1'b1;
            end else begin
               wcnt_nxt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
            end
         end
         default: ;
      endcase
   end
   always_comb begin
      pc_write    = 1'b1;
      ifd_write   = 1'b1;
      ifd_flush   = 1'b0;
      idex_bubble = 1'b0;
      case (cur)
         RUN: begin
            if (busy) begin
               pc_write  = 1'b0;
               ifd_write = 1'b0;
            end else if (branch) begin
               ifd_flush   = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               ifd_write   = 1'b0;
               idex_bubble = 1'b1;
            end
         end
         FLUSH: begin
            pc_write    = ~busy;
            ifd_write   = ~busy;
            ifd_flush   = ~busy;
            idex_bubble = ~busy;
         end
         MEM_WAIT: begin
            pc_write  = 1'b0;
            ifd_write = 1'b0;
         end
         default: begin
            pc_write    = 1'b0;
            ifd_write   = 1'b0;
            ifd_flush   = 1'b1;
            idex_bubble = 1'b1;
         end
      endcase
   end
`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= 16'd0;
      else if (!pc_write && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of consecutive IF/ID flush cycles after a taken branch; legal range 1..3.
REQ-002 Parameter MEM_TIMEOUT, default 15, number of consecutive mem_busy-high cycles that triggers ERROR; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_rs  input  5  Rs field of the instruction held in IF/ID.
REQ-006 id_rt  input  5  Rt field of the instruction held in IF/ID.
REQ-007 ex_mem_read  input  1  the instruction in EX is a load.
REQ-008 ex_rt  input  5  destination register of the load in EX.
REQ-009 is_branch  input  1  a taken branch was resolved this cycle.
REQ-010 mem_busy  input  1  data memory cannot accept or complete an access this cycle.
REQ-011 pc_write  output  1  PC update enable.
REQ-012 ifd_write  output  1  IF/ID register load enable.
REQ-013 ifd_flush  output  1  IF/ID loads NOP (32'd0) instead of the fetched word.
REQ-014 idex_bubble  output  1  zero the control fields entering ID/EX.
REQ-015 state  output  2  current FSM state (RUN=0, FLUSH=1, MEM_WAIT=2, ERROR=3).
REQ-016 timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-017 Outputs are a combinational decode of the registered state and the current inputs; the FSM, flush counter (2 bits) and wait counter (8 bits) are registered.
REQ-018 Load-use hazard = ex_mem_read AND ex_rt != 0 AND (ex_rt == id_rs OR ex_rt == id_rt).
REQ-019 RUN, priority mem_busy > is_branch > load-use > none.
REQ-020 RUN, none: pc_write=1, ifd_write=1, ifd_flush=0, idex_bubble=0; stay RUN.
REQ-021 RUN, mem_busy=1: pc_write=0, ifd_write=0, ifd_flush=0, idex_bubble=0; wait counter := 1; next MEM_WAIT.
REQ-022 RUN, is_branch=1: pc_write=1, ifd_write=1, ifd_flush=1, idex_bubble=1; flush counter := FLUSH_CYCLES-1; next FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-023 RUN, load-use: pc_write=0, ifd_write=0, ifd_flush=0, idex_bubble=1 for exactly that cycle; stay RUN.
REQ-024 FLUSH: pc_write=1, ifd_write=1, ifd_flush=1, idex_bubble=1; is_branch and load-use are ignored; counter decrements; counter==1 -> RUN at the next edge.
REQ-025 FLUSH with mem_busy=1: freeze outputs as in REQ-021; the flush counter is held (no decrement); next MEM_WAIT.
REQ-026 MEM_WAIT: pc_write=0, ifd_write=0, ifd_flush=0, idex_bubble=0 unconditionally; while mem_busy=1 the wait counter increments (saturating at 255).
REQ-027 MEM_WAIT with mem_busy=0: next FLUSH if the flush counter != 0, else RUN; the wait counter clears.
REQ-028 MEM_WAIT with the wait counter == MEM_TIMEOUT and mem_busy=1: next ERROR, and timeout_err := 1.
REQ-029 ERROR: pc_write=0, ifd_write=0, ifd_flush=1, idex_bubble=1; all inputs are ignored; exit is by reset only.

Reset
REQ-030 rst_n low asynchronously forces state=RUN, both counters=0, timeout_err=0, and stall_cnt=0 when present.
REQ-031 While rst_n is low, the outputs decode as RUN with all inputs treated as zero: pc_write=1, ifd_write=1, ifd_flush=0, idex_bubble=0.
REQ-032 Reset asserted in the middle of a FLUSH, MEM_WAIT or ERROR discards any pending flush or wait; no residual flush occurs after release.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined: extra output stall_cnt (16 bits) counts cycles with pc_write=0, saturating at 16'hFFFF.
REQ-034 Without HAZARD_PERF_CNT_EN: port stall_cnt and its register are absent; all other behaviour is identical.

Verification
REQ-035 ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle in RUN -> that cycle pc_write=0, ifd_write=0, idex_bubble=1; next cycle all normal.
REQ-036 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; pc_write=1.
REQ-037 FLUSH_CYCLES=3, is_branch pulse -> ifd_flush=1 for 3 consecutive cycles, state 0->1->1->0.
REQ-038 is_branch=1 and load-use in the same cycle -> flush wins: pc_write=1, ifd_flush=1.
REQ-039 MEM_TIMEOUT=4, mem_busy held high -> MEM_WAIT for 4 cycles, then state=3 and timeout_err=1; rst_n low -> state=0 and timeout_err=0 immediately.
REQ-040 FLUSH_CYCLES=2, is_branch, then mem_busy high for 2 cycles -> sequence FLUSH, MEM_WAIT, MEM_WAIT, FLUSH (1 cycle), RUN; with HAZARD_PERF_CNT_EN, stall_cnt=3.
